ref_win_mem: RTL and testbench

//  Parametrised multi-bank reference-window memory for the integer ME datapath. Pixel rows are

---
 rtl/ref_win_mem.sv | 109 ++++++++++
 tb/tb_ref_win_mem.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ref_win_mem.sv
// ref_win_mem: banked reference-window memory, column-wise writes, burst/single-row read FSM.
// Define REF_WIN_MEM_RDW_FWD_EN to forward a same-cycle write onto a colliding read.
module ref_win_mem #(
    parameter int PIXEL = 8,
    parameter int BANKS = 32,
    parameter int DEPTH = 128,
    parameter int ROWS  = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BANKS*PIXEL-1:0]      wr_data,
    input  logic [BANKS-1:0]            wr_bank_sel,
    input  logic [BANKS*AW-1:0]         wr_addr_all,
    input  logic                        rd_start,
    input  logic                        rd_mode,
    input  logic [AW-1:0]               rd_base_addr,
    output logic                        busy,
    output logic [BANKS*PIXEL-1:0]      rd_row_data,
    output logic                        rd_row_valid,
    output logic [ROWS*BANKS*PIXEL-1:0] rd_burst_data,
    output logic                        rd_burst_valid
);
    localparam int RW = BANKS * PIXEL;
    localparam int CW = $clog2(ROWS + 1);
    localparam logic [AW:0]   DEPTH_W    = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST_BURST = CW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state_q;
    logic                mode_q, busy_q, row_valid_q, burst_valid_q;
    logic [AW-1:0]       base_q;
    logic [CW-1:0]       cnt_q;
    logic [RW-1:0]       row_q;
    logic [ROWS*RW-1:0]  burst_q;
    logic [AW:0]         sum;
    logic [AW-1:0]       rd_addr;
    logic                last;
    logic [RW-1:0]       row_d;

    // base + row index, folded back into the array for non-power-of-two depths too
    always_comb begin
        sum     = {1'b0, base_q} + (AW + 1)'(cnt_q);
        rd_addr = (sum >= DEPTH_W) ? AW'(sum - DEPTH_W) : AW'(sum);
        last    = mode_q ? (cnt_q == '0) : (cnt_q == LAST_BURST);
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        logic [PIXEL-1:0] mem_q [DEPTH];
        logic [AW-1:0]    wa;
        logic [PIXEL-1:0] wd;
        assign wa = wr_addr_all[g*AW +: AW];
        assign wd = wr_data[g*PIXEL +: PIXEL];
        always_ff @(posedge clk) begin
            if (wr_bank_sel[g]) mem_q[wa] <= wd;
        end
`ifdef REF_WIN_MEM_RDW_FWD_EN
        assign row_d[g*PIXEL +: PIXEL] = (wr_bank_sel[g] && wa == rd_addr) ? wd : mem_q[rd_addr];
`else
        assign row_d[g*PIXEL +: PIXEL] = mem_q[rd_addr];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mode_q        <= 1'b0;
            base_q        <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            row_valid_q   <= 1'b0;
            burst_valid_q <= 1'b0;
            row_q         <= '0;
            burst_q       <= '0;
        end else begin
            row_valid_q   <= 1'b0;
            burst_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (rd_start) begin
                    state_q <= ISSUE;
                    busy_q  <= 1'b1;
                    mode_q  <= rd_mode;
                    base_q  <= rd_base_addr;
                    cnt_q   <= '0;
                end
                ISSUE: begin
                    row_q       <= row_d;
                    row_valid_q <= 1'b1;
                    if (!mode_q) burst_q[int'(cnt_q)*RW +: RW] <= row_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) state_q <= DRAIN;
                end
                DRAIN: begin
                    state_q       <= IDLE;
                    busy_q        <= 1'b0;
                    burst_valid_q <= !mode_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign rd_row_data    = row_q;
    assign rd_row_valid   = row_valid_q;
    assign rd_burst_data  = burst_q;
    assign rd_burst_valid = burst_valid_q;
endmodule

// File: tb/tb_ref_win_mem.sv
// tb_ref_win_mem: table-driven, directed and random checks of ref_win_mem against a row-array model.
// Honours REF_WIN_MEM_RDW_FWD_EN the same way as the design build.
module tb_ref_win_mem;
    localparam int PIXEL = 8;
    localparam int BANKS = 32;
    localparam int DEPTH = 128;
    localparam int ROWS  = 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = BANKS * PIXEL;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [RW-1:0]          wr_data = '0;
    logic [BANKS-1:0]       wr_bank_sel = '0;
    logic [BANKS*AW-1:0]    wr_addr_all = '0;
    logic                   rd_start = 1'b0;
    logic                   rd_mode = 1'b0;
    logic [AW-1:0]          rd_base_addr = '0;
    logic                   busy;
    logic [RW-1:0]          rd_row_data;
    logic                   rd_row_valid;
    logic [ROWS*RW-1:0]     rd_burst_data;
    logic                   rd_burst_valid;

    ref_win_mem dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_bank_sel(wr_bank_sel),
        .wr_addr_all(wr_addr_all), .rd_start(rd_start), .rd_mode(rd_mode),
        .rd_base_addr(rd_base_addr), .busy(busy), .rd_row_data(rd_row_data),
        .rd_row_valid(rd_row_valid), .rd_burst_data(rd_burst_data),
        .rd_burst_valid(rd_burst_valid)
    );

    always #5 clk = ~clk;

    logic [PIXEL-1:0] model [BANKS][DEPTH];
    logic [RW-1:0]    exp_burst [ROWS];
    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        bit         mode;
        int         base;
        logic [7:0] first_b;
        logic [7:0] last_b;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // one clock edge; the model takes the writes that were driven during the ending cycle
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < BANKS; k++)
            if (wr_bank_sel[k]) model[k][wr_addr_all[k*AW +: AW]] = wr_data[k*PIXEL +: PIXEL];
        #1;
    endtask

    task automatic wr_row(input int addr, input logic [7:0] val, input logic [BANKS-1:0] sel);
        wr_bank_sel = sel;
        for (int k = 0; k < BANKS; k++) wr_addr_all[k*AW +: AW] = AW'(addr);
        wr_data = {BANKS{val}};
        tick();
        wr_bank_sel = '0;
    endtask

    task automatic set_writes(input int wmode, input int i, input int row);
        wr_bank_sel = '0;
        if (wmode == 1) begin
            wr_bank_sel = $urandom;
            for (int k = 0; k < BANKS; k++) begin
                wr_addr_all[k*AW +: AW] = $urandom_range(0, 1) ? AW'(row) : AW'($urandom_range(0, DEPTH - 1));
                wr_data[k*PIXEL +: PIXEL] = PIXEL'($urandom);
            end
        end else if (wmode == 2 && i == 0) begin
            wr_bank_sel = '1;
            for (int k = 0; k < BANKS; k++) wr_addr_all[k*AW +: AW] = AW'(row);
            wr_data = {BANKS{8'h22}};
        end
    endtask

    // row as a read issued this cycle must return it
    function automatic logic [RW-1:0] exp_read(input int row);
        logic [RW-1:0] r;
        for (int k = 0; k < BANKS; k++) begin
            r[k*PIXEL +: PIXEL] = model[k][row];
`ifdef REF_WIN_MEM_RDW_FWD_EN
            if (wr_bank_sel[k] && wr_addr_all[k*AW +: AW] == AW'(row)) r[k*PIXEL +: PIXEL] = wr_data[k*PIXEL +: PIXEL];
`endif
        end
        return r;
    endfunction

    task automatic read_check(input bit mode, input int base, input int wmode, input bit hold,
                              output logic [RW-1:0] first, output logic [RW-1:0] last);
        int n;
        logic [RW-1:0] exp_rows [ROWS];
        logic [RW-1:0] got_rows [ROWS];
        n = mode ? 1 : ROWS;
        rd_start = 1'b1;
        rd_mode = mode;
        rd_base_addr = AW'(base);
        wr_bank_sel = '0;
        tick();
        rd_start = hold;
        chk("busy_first", busy, 1);
        chk("row_valid_first", rd_row_valid, 0);
        chk("burst_valid_first", rd_burst_valid, 0);
        for (int i = 0; i <= n; i++) begin
            set_writes(wmode, i, (base + i) % DEPTH);
            if (i < n) exp_rows[i] = exp_read((base + i) % DEPTH);
            tick();
            chk("busy", busy, i < n);
            chk("row_valid", rd_row_valid, i < n);
            if (i < n) begin
                got_rows[i] = rd_row_data;
                chk("row_data", rd_row_data, exp_rows[i]);
            end
            chk("burst_valid", rd_burst_valid, i == n && !mode);
        end
        wr_bank_sel = '0;
        if (!mode) for (int s = 0; s < ROWS; s++) exp_burst[s] = exp_rows[s];
        for (int s = 0; s < ROWS; s++) chk("burst_data", rd_burst_data[s*RW +: RW], exp_burst[s]);
        first = got_rows[0];
        last = got_rows[n-1];
    endtask

    initial begin
        logic [RW-1:0] f, l;
        logic bad;
        tbl[0] = '{0, 0,   8'h01, 8'h08};
        tbl[1] = '{1, 5,   8'h06, 8'h06};
        tbl[2] = '{0, 120, 8'h79, 8'h80};
        tbl[3] = '{1, 127, 8'h80, 8'h80};
        tbl[4] = '{0, 64,  8'h41, 8'h48};
        tbl[5] = '{0, 125, 8'h7E, 8'h05};
        tbl[6] = '{1, 0,   8'h01, 8'h01};
        for (int s = 0; s < ROWS; s++) exp_burst[s] = '0;

        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_row_valid", rd_row_valid, 0);
        chk("rst_burst_valid", rd_burst_valid, 0);
        chk("rst_row_data", rd_row_data, '0);
        for (int s = 0; s < ROWS; s++) chk("rst_burst_data", rd_burst_data[s*RW +: RW], '0);
        rst = 1'b0;

        for (int r = 0; r < DEPTH; r++) wr_row(r, 8'(r + 1), '1);

        for (int j = 0; j < 7; j++) begin
            read_check(tbl[j].mode, tbl[j].base, 0, 0, f, l);
            chk("tbl_first_row", f, {BANKS{tbl[j].first_b}});
            chk("tbl_last_row", l, {BANKS{tbl[j].last_b}});
        end

        wr_row(126, 8'hAA, '1);
        wr_row(127, 8'hBB, '1);
        for (int r = 0; r < 6; r++) wr_row(r, 8'(r), '1);
        read_check(0, 126, 0, 0, f, l);
        chk("wrap_slot0", rd_burst_data[0*RW +: RW], {BANKS{8'hAA}});
        chk("wrap_slot1", rd_burst_data[1*RW +: RW], {BANKS{8'hBB}});
        chk("wrap_slot2", rd_burst_data[2*RW +: RW], {BANKS{8'h00}});
        chk("wrap_slot7", rd_burst_data[7*RW +: RW], {BANKS{8'h05}});

        wr_row(0, 8'h5C, '1);
        wr_row(0, 8'h01, 32'h0000000F);
        wr_row(0, 8'h02, 32'h000000F0);
        read_check(1, 0, 0, 0, f, l);
        chk("bank_sel_row", f, {{24{8'h5C}}, {4{8'h02}}, {4{8'h01}}});

        wr_row(3, 8'h11, '1);
        read_check(1, 3, 2, 0, f, l);
`ifdef REF_WIN_MEM_RDW_FWD_EN
        chk("rdw_same_cycle", f, {BANKS{8'h22}});
`else
        chk("rdw_same_cycle", f, {BANKS{8'h11}});
`endif
        read_check(1, 3, 0, 0, f, l);
        chk("rdw_reread", f, {BANKS{8'h22}});

        read_check(0, 10, 0, 1, f, l);
        read_check(0, 40, 0, 1, f, l);
        rd_base_addr = AW'(0);
        rd_mode = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        rd_start = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_row_valid", rd_row_valid, 0);
        chk("abort_burst_valid", rd_burst_valid, 0);
        chk("abort_row_data", rd_row_data, '0);
        for (int s = 0; s < ROWS; s++) begin
            exp_burst[s] = '0;
            chk("abort_burst_data", rd_burst_data[s*RW +: RW], '0);
        end
        bad = 1'b0;
        repeat (12) begin
            tick();
            if (rd_burst_valid || rd_row_valid || busy) bad = 1'b1;
        end
        chk("abort_no_valid", bad, 0);

        repeat (30) begin
            repeat ($urandom_range(0, 3)) begin
                set_writes(1, 0, $urandom_range(0, DEPTH - 1));
                tick();
            end
            read_check(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), 1, 0, f, l);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
